chunk_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits
//  per clock through one CHUNK-bit adder slice and a registered carry.

---
 rtl/chunk_serial_adder.sv | 138 +++++++++++++
 tb/tb_chunk_serial_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock through a
// single CHUNK-bit adder slice with a registered carry, avoiding a full-width carry chain.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; a_in, b_in, c_in, sub sampled on accept
//   out_valid / out_ready result handshake; sum, carry, overflow held until the next result
//   busy                  an operation is in progress (not idle)
//
// sub=0: sum = a + b + c_in.  sub=1: sum = a - b - c_in (carry=1 means no borrow).
module chunk_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SafeChunk = (CHUNK < 1) ? 1 : CHUNK;
  localparam int unsigned NCHUNK    = WIDTH / SafeChunk;
  localparam int unsigned IdxW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % SafeChunk) != 0)) begin : g_param_check
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted down one chunk per RUN cycle
  logic [WIDTH-1:0] b_q, b_d;       // effective operand B (inverted for subtract), shifted likewise
  logic             cy_q, cy_d;     // inter-chunk carry
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d; // partial result, filled from the top down
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Current chunk always sits in the low bits of the shifting operand registers.
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] work_next;

  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];
  assign {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cy_q};
  // After NCHUNK insertions at the top, chunk 0 has been shifted down to bit 0.
  assign work_next = (work_q >> CHUNK) | (WIDTH'(s_sl) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          cy_d    = sub ? ~c_in : c_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        cy_d   = c_sl;
        work_d = work_next;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // On the last chunk the slice MSBs are the operand MSBs.
          sum_d   = work_next;
          carry_d = c_sl;
          ovf_d   = (a_sl[CHUNK-1] == b_sl[CHUNK-1]) && (s_sl[CHUNK-1] != a_sl[CHUNK-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: a 32/8 instance and a 32/32 instance share stimulus and are
// compared against an arithmetic reference model.
module tb_chunk_serial_adder;

  localparam longint SMax = (longint'(1) << 31) - 1;
  localparam longint SMin = -(longint'(1) << 31);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, c_in, sub, out_ready;
  logic [31:0] a_in, b_in;

  logic        in_ready0, out_valid0, carry0, ovf0, busy0;
  logic [31:0] sum0;
  logic        in_ready1, out_valid1, carry1, ovf1, busy1;
  logic [31:0] sum1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev0, prev1;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub(sub),
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .carry(carry0), .overflow(ovf0), .busy(busy0)
  );

  chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .carry(carry1), .overflow(ovf1), .busy(busy1)
  );

  // Returns {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic s);
    longint ua, ub, sa, sb, us, ss;
    logic   cy, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      us = ua + ub + longint'(ci);
      ss = sa + sb + longint'(ci);
      cy = (us > 64'sd4294967295);
    end else begin
      us = ua - ub - longint'(ci);
      ss = sa - sb - longint'(ci);
      cy = (us >= 0);
    end
    ov = (ss > SMax) || (ss < SMin);
    return {ov, cy, us[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at the negedge following the accept edge; waits for both results and checks them.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic s);
    logic [33:0] e;
    int          lat0, lat1;
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!out_valid0) check("sum8_held_during_run", 64'(sum0), 64'(prev0));
      else if (lat0 == 0) lat0 = k;
      if (out_valid1 && lat1 == 0) lat1 = k;
      if (lat0 != 0 && lat1 != 0) break;
    end
    e = model(a, b, ci, s);
    check("latency8", 64'(lat0), 64'd4);
    check("latency32", 64'(lat1), 64'd1);
    check("sum8", 64'(sum0), 64'(e[31:0]));
    check("carry8", 64'(carry0), 64'(e[32]));
    check("ovf8", 64'(ovf0), 64'(e[33]));
    check("sum32", 64'(sum1), 64'(e[31:0]));
    check("carry32", 64'(carry1), 64'(e[32]));
    check("ovf32", 64'(ovf1), 64'(e[33]));
    prev0 = e[31:0];
    prev1 = e[31:0];
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic s);
    @(negedge clk);
    check("ready8_before_op", 64'(in_ready0), 64'd1);
    a_in     = a;
    b_in     = b;
    c_in     = ci;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble inputs after accept; they must be ignored.
    a_in     = $urandom;
    b_in     = $urandom;
    c_in     = ~ci;
    sub      = ~s;
    wait_result(a, b, ci, s);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid8_drops", 64'(out_valid0), 64'd0);
    check("ready8_back", 64'(in_ready0), 64'd1);
    check("sum8_kept_in_idle", 64'(sum0), 64'(prev0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    prev0     = '0;
    prev1     = '0;

    #12;
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_sum", 64'(sum0), 64'd0);
    check("rst_carry", 64'(carry0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_sum32", 64'(sum1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    release_result();
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    release_result();
    do_op(32'd5, 32'd7, 1'b0, 1'b1);
    release_result();
    do_op(32'd7, 32'd5, 1'b1, 1'b1);

    // Backpressure: hold the result while a new request waits
    a_in     = 32'h8000_0000;
    b_in     = 32'h8000_0000;
    c_in     = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid0), 64'd1);
      check("bp_in_ready", 64'(in_ready0), 64'd0);
      check("bp_sum", 64'(sum0), 64'(prev0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid0), 64'd0);
    check("bp_release_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted_busy", 64'(busy0), 64'd1);
    wait_result(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    release_result();

    // Reset after two chunks
    @(negedge clk);
    a_in     = 32'h1234_5678;
    b_in     = 32'h0F0F_0F0F;
    c_in     = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sum", 64'(sum0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_in_ready", 64'(in_ready0), 64'd1);
    check("midrst_out_valid", 64'(out_valid0), 64'd0);
    check("midrst_carry", 64'(carry0), 64'd0);
    check("midrst_sum32", 64'(sum1), 64'd0);
    check("midrst_valid32", 64'(out_valid1), 64'd0);
    prev0 = '0;
    prev1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
    release_result();

    // Random operations
    for (int i = 0; i < 24; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      release_result();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
